// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 4-way round-robin output arbiter.
package rr_arb_pkg;

  localparam int NREQ = 4;

  typedef logic [1:0] req_idx_t;

  typedef enum logic {IDLE, BUSY} arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first requester after ptr, wrapping, ptr itself last.
module rr_pick4
  import rr_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  // Scan lowest priority first so the highest-priority hit is the final assignment.
  always_comb begin
    req_idx_t cand;
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + req_idx_t'(k);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output among 4 requesters.
module rr_mux4_arbiter
  import rr_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            req,
  input  logic [NREQ*WIDTH-1:0] d,
  output logic [3:0]            ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [1:0]            out_sel,
  output logic                  busy
);

  if (NREQ != rr_arb_pkg::NREQ) begin : g_bad_nreq
    $error("rr_mux4_arbiter supports exactly 4 requesters");
  end

  arb_state_t       state_q, state_d;
  req_idx_t         ptr_q, sel_q, pick_ptr, pick_idx;
  logic             pick_found, xfer, load;
  logic [WIDTH-1:0] data_q, pick_data;

  assign out_valid = (state_q == BUSY);
  assign busy      = (state_q == BUSY);
  assign xfer      = out_valid & out_ready;
  assign out_data  = data_q;
  assign out_sel   = sel_q;

  // On a transfer the rotation restarts just after the owner being released.
  assign pick_ptr = (state_q == BUSY) ? sel_q : ptr_q;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == req_idx_t'(i)) pick_data = d[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BUSY;
          load    = 1'b1;
        end
      end
      BUSY: begin
        if (xfer) begin
          if (pick_found) load = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) ptr_q <= sel_q;
      if (load) begin
        sel_q  <= pick_idx;
        data_q <= pick_data;
      end
    end
  end

  always_comb begin
    ack = '0;
    if (xfer) ack[sel_q] = 1'b1;
  end

endmodule
